// File: rtl/cache_pkg.sv
// Shared types and address-split constants for the cache tag lookup block.
package cache_pkg;

    localparam int ADDR_W   = 12;
    localparam int TAG_W    = 5;
    localparam int SET_W    = 3;
    localparam int OFF_W    = 4;
    localparam int NUM_SETS = 8;

    // One tag-array entry; field order matches the downstream tag format.
    typedef struct packed {
        logic             valid;
        logic             dirty;
        logic [TAG_W-1:0] tag;
    } tag_entry_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RESP      = 2'd1,
        FILL_WAIT = 2'd2
    } lookup_state_t;

endpackage

// File: rtl/cache_lru_ctrl.sv
// Per-set LRU age tracking. Each way carries an age; 0 is most recently used
// and WAYS-1 is least recently used. The ages within a set always form a
// permutation of 0..WAYS-1.
module cache_lru_ctrl
    import cache_pkg::*;
#(
    parameter int WAYS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     touch_en,
    input  logic [SET_W-1:0]         touch_set,
    input  logic [$clog2(WAYS)-1:0]  touch_way,
    input  logic [SET_W-1:0]         query_set,
    output logic [$clog2(WAYS)-1:0]  victim_way
);

    localparam int WW = $clog2(WAYS);

    logic [WW-1:0] ages [NUM_SETS][WAYS];
    logic [WW-1:0] touch_age;

    assign touch_age = ages[touch_set][touch_way];

    // Age update: touched way becomes 0, every younger way ages by one.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    ages[s][w] <= WW'(w);
                end
            end
        end else if (touch_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (w == int'(touch_way)) begin
                    ages[touch_set][w] <= '0;
                end else if (ages[touch_set][w] < touch_age) begin
                    ages[touch_set][w] <= ages[touch_set][w] + 1'b1;
                end
            end
        end
    end

    // Oldest way of the queried set.
    always_comb begin
        victim_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (ages[query_set][w] == WW'(WAYS - 1)) begin
                victim_way = WW'(w);
            end
        end
    end

endmodule

// File: rtl/cache_tag_lookup.sv
// Tag lookup stage of the cache read/replace block. Owns the tag array and LRU
// state, reports hit/miss, hit or victim way and victim write-back info, and
// installs the new tag once the downstream refill completes.
// Optional hit/miss statistics counters: define CACHE_LOOKUP_STATS_EN.
module cache_tag_lookup
    import cache_pkg::*;
#(
    parameter int WAYS   = 4,
    parameter int STAT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic                     req_write,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic                     resp_hit,
    output logic [$clog2(WAYS)-1:0]  resp_way,
    output logic [SET_W-1:0]         resp_set,
    output logic [OFF_W-1:0]         resp_offset,
    output logic                     victim_dirty,
    output logic [TAG_W-1:0]         victim_tag,
    input  logic                     fill_done,
    output logic [STAT_W-1:0]        hit_count,
    output logic [STAT_W-1:0]        miss_count
);

    localparam int WW = $clog2(WAYS);

    lookup_state_t state;
    tag_entry_t    tag_mem [NUM_SETS][WAYS];

    logic [TAG_W-1:0] req_tag;
    logic [SET_W-1:0] req_set;
    logic [OFF_W-1:0] req_off;
    logic [TAG_W-1:0] lat_tag;
    logic             lat_write;

    logic [WAYS-1:0]  match_vec;
    logic             hit_lk;
    logic [WW-1:0]    hit_way_lk;
    logic             inv_found;
    logic [WW-1:0]    inv_way;
    logic [WW-1:0]    lru_victim;
    logic [WW-1:0]    vic_way;
    tag_entry_t       vic_entry;

    logic             accept;
    logic             hit_hs;
    logic             miss_hs;
    logic             fill_en;

    assign req_tag = req_addr[11:7];
    assign req_set = req_addr[6:4];
    assign req_off = req_addr[3:0];

    assign accept  = (state == IDLE) && req_ready && req_valid;
    assign hit_hs  = (state == RESP) && resp_ready && resp_hit;
    assign miss_hs = (state == RESP) && resp_ready && !resp_hit;
    assign fill_en = (state == FILL_WAIT) && fill_done;

    // Tag compare and lowest-index invalid way for the incoming request's set.
    always_comb begin
        match_vec  = '0;
        hit_way_lk = '0;
        inv_found  = 1'b0;
        inv_way    = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (tag_mem[req_set][w].valid && (tag_mem[req_set][w].tag == req_tag)) begin
                match_vec[w] = 1'b1;
                hit_way_lk   = WW'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!tag_mem[req_set][w].valid) begin
                inv_found = 1'b1;
                inv_way   = WW'(w);
            end
        end
    end

    assign hit_lk    = |match_vec;
    assign vic_way   = inv_found ? inv_way : lru_victim;
    assign vic_entry = tag_mem[req_set][vic_way];

    cache_lru_ctrl #(
        .WAYS (WAYS)
    ) u_lru (
        .clk        (clk),
        .rst        (rst),
        .touch_en   (hit_hs || fill_en),
        .touch_set  (resp_set),
        .touch_way  (resp_way),
        .query_set  (req_set),
        .victim_way (lru_victim)
    );

    // Request FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            req_ready    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_hit     <= 1'b0;
            resp_way     <= '0;
            resp_set     <= '0;
            resp_offset  <= '0;
            victim_dirty <= 1'b0;
            victim_tag   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        assert ($onehot0(match_vec))
                            else $error("cache_tag_lookup: multiple ways match one tag");
                        req_ready    <= 1'b0;
                        resp_valid   <= 1'b1;
                        resp_hit     <= hit_lk;
                        resp_way     <= hit_lk ? hit_way_lk : vic_way;
                        resp_set     <= req_set;
                        resp_offset  <= req_off;
                        victim_dirty <= !hit_lk && vic_entry.valid && vic_entry.dirty;
                        victim_tag   <= hit_lk ? '0 : vic_entry.tag;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        if (resp_hit) begin
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state     <= FILL_WAIT;
                        end
                    end
                end
                FILL_WAIT: begin
                    if (fill_done) begin
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                end
            endcase
        end
    end

    // Request tag and write flag captured at accept; needed later for fill.
    always_ff @(posedge clk) begin
        if (accept) begin
            lat_tag   <= req_tag;
            lat_write <= req_write;
        end
    end

    // Tag array: dirty on write hit, full entry install on refill completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    tag_mem[s][w] <= '0;
                end
            end
        end else if (hit_hs && lat_write) begin
            tag_mem[resp_set][resp_way].dirty <= 1'b1;
        end else if (fill_en) begin
            tag_mem[resp_set][resp_way] <= '{valid: 1'b1, dirty: lat_write, tag: lat_tag};
        end
    end

`ifdef CACHE_LOOKUP_STATS_EN
    logic [STAT_W-1:0] hit_cnt;
    logic [STAT_W-1:0] miss_cnt;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Saturating hit/miss counters, one step per completed response handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_hs)  hit_cnt  <= sat_inc(hit_cnt);
            if (miss_hs) miss_cnt <= sat_inc(miss_cnt);
        end
    end

    assign hit_count  = hit_cnt;
    assign miss_count = miss_cnt;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Self-checking bench for cache_tag_lookup with a recency-list reference model.
module tb_cache_tag_lookup;
    localparam int WAYS   = 4;
    localparam int WW     = 2;
    localparam int STAT_W = 4;
    localparam int SATMAX = (1 << STAT_W) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [11:0]       req_addr = '0;
    logic              req_write = 1'b0;
    logic              resp_valid;
    logic              resp_ready = 1'b0;
    logic              resp_hit;
    logic [WW-1:0]     resp_way;
    logic [2:0]        resp_set;
    logic [3:0]        resp_offset;
    logic              victim_dirty;
    logic [4:0]        victim_tag;
    logic              fill_done = 1'b0;
    logic [STAT_W-1:0] hit_count;
    logic [STAT_W-1:0] miss_count;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: contents per set/way plus a recency list (MRU first).
    bit         m_valid [8][WAYS];
    bit         m_dirty [8][WAYS];
    logic [4:0] m_tag   [8][WAYS];
    int         m_list  [8][WAYS];
    int         m_hits;
    int         m_misses;

    always #5 clk = ~clk;

    cache_tag_lookup #(.WAYS(WAYS), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_write(req_write),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_hit(resp_hit), .resp_way(resp_way),
        .resp_set(resp_set), .resp_offset(resp_offset),
        .victim_dirty(victim_dirty), .victim_tag(victim_tag),
        .fill_done(fill_done),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    function automatic void model_reset();
        for (int s = 0; s < 8; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
                m_tag[s][w]   = '0;
                m_list[s][w]  = w;
            end
        end
        m_hits   = 0;
        m_misses = 0;
    endfunction

    function automatic void model_touch(input int s, input int w);
        int p;
        p = 0;
        for (int k = 0; k < WAYS; k++) if (m_list[s][k] == w) p = k;
        for (int k = p; k > 0; k--) m_list[s][k] = m_list[s][k-1];
        m_list[s][0] = w;
    endfunction

    function automatic int exp_count(input int c);
`ifdef CACHE_LOOKUP_STATS_EN
        return c;
`else
        return 0;
`endif
    endfunction

    // One full transaction: accept, check response, optional stall, handshake, optional fill.
    task automatic access(input logic [11:0] addr, input bit wr, input int hold, input bit do_fill,
                          output bit g_hit, output logic [WW-1:0] g_way,
                          output bit g_vd, output logic [4:0] g_vt);
        int s, ew, n;
        bit eh, evd;
        logic [4:0] t, evt;
        logic [3:0] eo;
        s  = int'(addr[6:4]);
        t  = addr[11:7];
        eo = addr[3:0];
        eh = 0; ew = -1; evd = 0; evt = '0;
        for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == t) begin eh = 1; ew = w; end
        if (!eh) begin
            for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) ew = w;
            if (ew < 0) ew = m_list[s][WAYS-1];
            evd = m_valid[s][ew] && m_dirty[s][ew];
            evt = m_tag[s][ew];
        end

        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_wait addr=%h req_ready=%b required 1", addr, req_ready);
        end
        req_valid = 1'b1; req_addr = addr; req_write = wr;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0;
        g_hit = resp_hit; g_way = resp_way; g_vd = victim_dirty; g_vt = victim_tag;

        vectors++;
        if ({resp_valid, resp_hit, req_ready} !== {1'b1, eh, 1'b0}) begin
            miscompares++;
            $display("FAIL resp_hit addr=%h got v/hit/rdy=%b%b%b required 1%b0", addr, resp_valid, resp_hit, req_ready, eh);
        end
        vectors++;
        if (resp_way !== WW'(ew)) begin
            miscompares++;
            $display("FAIL resp_way addr=%h got %0d required %0d", addr, resp_way, ew);
        end
        vectors++;
        if ({resp_set, resp_offset} !== {addr[6:4], eo}) begin
            miscompares++;
            $display("FAIL set_off addr=%h got %h/%h required %h/%h", addr, resp_set, resp_offset, addr[6:4], eo);
        end
        vectors++;
        if (victim_dirty !== evd) begin
            miscompares++;
            $display("FAIL victim_dirty addr=%h got %b required %b", addr, victim_dirty, evd);
        end
        if (!eh) begin
            vectors++;
            if (victim_tag !== evt) begin
                miscompares++;
                $display("FAIL victim_tag addr=%h got %h required %h", addr, victim_tag, evt);
            end
        end

        for (int k = 0; k < hold; k++) begin
            req_valid = 1'b1;
            req_addr  = 12'($urandom);
            fill_done = 1'($urandom);
            @(negedge clk);
            vectors++;
            if ({resp_valid, req_ready, resp_hit, resp_way, resp_set, resp_offset, victim_dirty}
                !== {1'b1, 1'b0, eh, WW'(ew), addr[6:4], eo, evd}) begin
                miscompares++;
                $display("FAIL stall_hold cyc=%0d got v=%b rdy=%b hit=%b way=%0d vd=%b required 1 0 %b %0d %b",
                         k, resp_valid, req_ready, resp_hit, resp_way, victim_dirty, eh, ew, evd);
            end
        end
        req_valid = 1'b0; fill_done = 1'b0; resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        resp_ready = 1'b0;

        if (eh) begin
            model_touch(s, ew);
            if (wr) m_dirty[s][ew] = 1;
            if (m_hits < SATMAX) m_hits++;
            vectors++;
            if ({req_ready, resp_valid} !== 2'b10) begin
                miscompares++;
                $display("FAIL after_hit got rdy=%b v=%b required 1 0", req_ready, resp_valid);
            end
        end else begin
            if (m_misses < SATMAX) m_misses++;
            vectors++;
            if ({req_ready, resp_valid} !== 2'b00) begin
                miscompares++;
                $display("FAIL fill_wait got rdy=%b v=%b required 0 0", req_ready, resp_valid);
            end
            if (do_fill) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                fill_done = 1'b1;
                @(posedge clk); @(negedge clk);
                fill_done = 1'b0;
                m_valid[s][ew] = 1; m_dirty[s][ew] = wr; m_tag[s][ew] = t;
                model_touch(s, ew);
                vectors++;
                if (req_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL after_fill got rdy=%b required 1", req_ready);
                end
            end
        end
        vectors++;
        if (hit_count !== STAT_W'(exp_count(m_hits)) || miss_count !== STAT_W'(exp_count(m_misses))) begin
            miscompares++;
            $display("FAIL counters got hit=%0d miss=%0d required %0d %0d",
                     hit_count, miss_count, exp_count(m_hits), exp_count(m_misses));
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        vectors++;
        if ({req_ready, resp_valid, resp_hit, resp_way, resp_set, resp_offset, victim_dirty, victim_tag} !== '0
            || hit_count !== '0 || miss_count !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs rdy=%b v=%b hit=%b way=%0d set=%0d off=%0d vd=%b vt=%h hc=%0d mc=%0d required all 0",
                     req_ready, resp_valid, resp_hit, resp_way, resp_set, resp_offset, victim_dirty, victim_tag,
                     hit_count, miss_count);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready got %b required 1", req_ready);
        end
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_basic();
        bit h, vd; logic [WW-1:0] w; logic [4:0] vt;
        access(12'h0A5, 0, 0, 1, h, w, vd, vt);
        vectors++;
        if ({h, w, vd} !== {1'b0, 2'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL basic_miss got hit=%b way=%0d vd=%b required 0 0 0", h, w, vd);
        end
        access(12'h0A5, 0, 0, 1, h, w, vd, vt);
        vectors++;
        if ({h, w} !== {1'b1, 2'd0}) begin
            miscompares++;
            $display("FAIL basic_rehit got hit=%b way=%0d required 1 0", h, w);
        end
    endtask

    task automatic test_dirty_victim();
        bit h, vd; logic [WW-1:0] w; logic [4:0] vt;
        access(12'h0A3, 1, 0, 1, h, w, vd, vt);
        vectors++;
        if ({h, w} !== {1'b1, 2'd0}) begin
            miscompares++;
            $display("FAIL write_hit got hit=%b way=%0d required 1 0", h, w);
        end
        access(12'h1A0, 0, 0, 1, h, w, vd, vt);
        access(12'h2A0, 0, 0, 1, h, w, vd, vt);
        access(12'h3A0, 0, 0, 1, h, w, vd, vt);
        access(12'h4A0, 0, 0, 1, h, w, vd, vt);
        vectors++;
        if ({h, w, vd, vt} !== {1'b0, 2'd0, 1'b1, 5'h01}) begin
            miscompares++;
            $display("FAIL dirty_victim got hit=%b way=%0d vd=%b vt=%h required 0 0 1 01", h, w, vd, vt);
        end
    endtask

    task automatic test_lru();
        bit h, vd; logic [WW-1:0] w; logic [4:0] vt;
        access(12'h000, 0, 0, 1, h, w, vd, vt);
        access(12'h080, 0, 0, 1, h, w, vd, vt);
        access(12'h100, 0, 0, 1, h, w, vd, vt);
        access(12'h180, 0, 0, 1, h, w, vd, vt);
        access(12'h004, 0, 0, 1, h, w, vd, vt);
        access(12'h200, 0, 0, 1, h, w, vd, vt);
        vectors++;
        if ({h, w} !== {1'b0, 2'd1}) begin
            miscompares++;
            $display("FAIL lru_victim got hit=%b way=%0d required 0 1", h, w);
        end
    endtask

    task automatic test_stall();
        bit h, vd; logic [WW-1:0] w; logic [4:0] vt;
        access(12'h0A5, 0, 5, 1, h, w, vd, vt);
        access(12'h7F3, 1, 5, 1, h, w, vd, vt);
    endtask

    task automatic test_reset_in_fill();
        bit h, vd; logic [WW-1:0] w; logic [4:0] vt;
        do_reset();
        access(12'h555, 0, 0, 0, h, w, vd, vt);
        do_reset();
        fill_done = 1'b1;
        @(negedge clk);
        fill_done = 1'b0;
        access(12'h555, 0, 0, 1, h, w, vd, vt);
        vectors++;
        if (h !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fill_remiss got hit=%b required 0", h);
        end
    endtask

    task automatic test_random();
        bit h, vd; logic [WW-1:0] w; logic [4:0] vt;
        logic [11:0] a;
        for (int i = 0; i < 150; i++) begin
            a = {5'($urandom_range(0, 5)), 3'($urandom), 4'($urandom)};
            if ($urandom_range(0, 3) == 0) begin
                fill_done = 1'b1;
                @(negedge clk);
                fill_done = 1'b0;
            end
            access(a, 1'($urandom), $urandom_range(0, 2), 1, h, w, vd, vt);
        end
    endtask

    task automatic test_stats();
        bit h, vd; logic [WW-1:0] w; logic [4:0] vt;
        do_reset();
        access(12'h0A5, 0, 0, 1, h, w, vd, vt);
        for (int i = 0; i < 20; i++) access(12'h0A5, 0, 0, 1, h, w, vd, vt);
        vectors++;
`ifdef CACHE_LOOKUP_STATS_EN
        if (hit_count !== 4'd15 || miss_count !== 4'd1) begin
            miscompares++;
            $display("FAIL stats_sat got hit=%0d miss=%0d required 15 1", hit_count, miss_count);
        end
`else
        if (hit_count !== 4'd0 || miss_count !== 4'd0) begin
            miscompares++;
            $display("FAIL stats_off got hit=%0d miss=%0d required 0 0", hit_count, miss_count);
        end
`endif
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_dirty_victim();
        test_lru();
        test_stall();
        test_reset_in_fill();
        test_random();
        test_stats();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
